// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: holds MIE/MIP/MTVEC, arbitrates pending enabled
// interrupts by fixed priority and presents one request to the pipeline via req/ack.
module irq_ctrl #(
    parameter int NUM_LOCAL = 16,
    parameter logic [((NUM_LOCAL > 0) ? NUM_LOCAL : 1)-1:0] EDGE_MASK = '0
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      mei_i,
    input  logic                                      msi_i,
    input  logic                                      mti_i,
    input  logic [((NUM_LOCAL > 0) ? NUM_LOCAL : 1)-1:0] local_irq_i,
    input  logic                                      mstatus_mie_i,
    input  logic                                      csr_we_i,
    input  logic [11:0]                               csr_addr_i,
    input  logic [31:0]                               csr_wdata_i,
    output logic [31:0]                               csr_rdata_o,
    output logic                                      irq_req_o,
    output logic [31:0]                               irq_cause_o,
    output logic [31:0]                               irq_target_o,
    input  logic                                      irq_ack_i
);

    localparam logic [11:0] ADDR_MIE   = 12'h304;
    localparam logic [11:0] ADDR_MTVEC = 12'h305;
    localparam logic [11:0] ADDR_MIP   = 12'h344;

    localparam logic [31:0] LOCAL_BITS =
        (NUM_LOCAL == 0) ? 32'h0 : ((32'h0000_FFFF >> (16 - NUM_LOCAL)) << 16);
    localparam logic [31:0] IMPL_BITS  = LOCAL_BITS | 32'h0000_0888;
    localparam logic [31:0] EDGE_BITS  = ({16'h0, 16'(EDGE_MASK)} << 16) & LOCAL_BITS;
    localparam logic [31:0] LEVEL_BITS = IMPL_BITS & ~EDGE_BITS;

    typedef enum logic {IDLE, REQ} state_t;

    state_t      state_q, state_d;
    logic [31:0] in_vec, mip_q, mip_d, mie_q, edge_prev_q;
    logic [31:0] active, edge_set, ack_clr, csr_clr, win_target;
    logic [29:0] mtvec_base_q;
    logic        mtvec_vec_q;
    logic        win_valid, latch, ack_fire;
    logic [4:0]  win_cause;

    always_comb begin
        in_vec     = '0;
        in_vec[3]  = msi_i;
        in_vec[7]  = mti_i;
        in_vec[11] = mei_i;
        for (int k = 0; k < NUM_LOCAL; k++) in_vec[16+k] = local_irq_i[k];
    end

    assign active   = mip_q & mie_q & {32{mstatus_mie_i}};
    assign ack_fire = (state_q == REQ) && irq_ack_i;
    assign edge_set = in_vec & ~edge_prev_q & EDGE_BITS;
    assign ack_clr  = ack_fire ? (32'h1 << irq_cause_o[4:0]) : 32'h0;
    assign csr_clr  = (csr_we_i && csr_addr_i == ADDR_MIP) ? ~csr_wdata_i : 32'h0;
    // A fresh edge overrides any clear arriving in the same cycle.
    assign mip_d    = (in_vec & LEVEL_BITS)
                    | ((edge_set | (mip_q & ~(ack_clr | csr_clr))) & EDGE_BITS);

    // Later assignments override earlier ones, so the lowest-priority source goes first.
    always_comb begin
        win_valid = 1'b0;
        win_cause = '0;
        for (int k = NUM_LOCAL - 1; k >= 0; k--) begin
            if (active[16+k]) begin
                win_valid = 1'b1;
                win_cause = 5'(16 + k);
            end
        end
        if (active[7])  begin win_valid = 1'b1; win_cause = 5'd7;  end
        if (active[3])  begin win_valid = 1'b1; win_cause = 5'd3;  end
        if (active[11]) begin win_valid = 1'b1; win_cause = 5'd11; end
        win_target = {mtvec_base_q, 2'b00}
                   + (mtvec_vec_q ? {25'd0, win_cause, 2'b00} : 32'd0);
    end

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = REQ;
                    latch   = 1'b1;
                end
            end
            REQ: begin
                if (irq_ack_i || !active[irq_cause_o[4:0]]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            irq_cause_o  <= '0;
            irq_target_o <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                irq_cause_o  <= {1'b1, 25'd0, 1'b0, win_cause};
                irq_target_o <= win_target;
            end
        end
    end

    assign irq_req_o = (state_q == REQ);

    always_ff @(posedge clk) begin
        if (reset) begin
            mip_q        <= '0;
            edge_prev_q  <= '0;
            mie_q        <= '0;
            mtvec_base_q <= '0;
            mtvec_vec_q  <= 1'b0;
        end else begin
            mip_q       <= mip_d;
            edge_prev_q <= in_vec & EDGE_BITS;
            if (csr_we_i) begin
                case (csr_addr_i)
                    ADDR_MIE: mie_q <= csr_wdata_i & IMPL_BITS;
                    ADDR_MTVEC: begin
                        mtvec_base_q <= csr_wdata_i[31:2];
                        // Reserved modes 2/3 keep the current mode.
                        if (!csr_wdata_i[1]) mtvec_vec_q <= csr_wdata_i[0];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        case (csr_addr_i)
            ADDR_MIE:   csr_rdata_o = mie_q;
            ADDR_MIP:   csr_rdata_o = mip_q;
            ADDR_MTVEC: csr_rdata_o = {mtvec_base_q, 1'b0, mtvec_vec_q};
            default:    csr_rdata_o = 32'h0;
        endcase
    end

endmodule
